// File: rtl/craps_game_ctrl.sv
// Two-dice craps sequencer: free-running dice counters, roll capture on a
// synchronised button edge, and come-out/point evaluation for the display block.
module craps_game_ctrl #(
    parameter logic [7:0] SAT_ROLLS = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_roll_btn,
    output logic [3:0] o_dice1,
    output logic [3:0] o_dice2,
    output logic [3:0] o_point,
    output logic       o_point_active,
    output logic       o_win,
    output logic       o_lose,
    output logic [7:0] o_roll_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EVAL1 = 3'd1;
    localparam logic [2:0] POINT = 3'd2;
    localparam logic [2:0] EVAL2 = 3'd3;
    localparam logic [2:0] WIN   = 3'd4;
    localparam logic [2:0] LOSE  = 3'd5;

    logic [2:0] r_state;
    logic       r_s1, r_s2, r_s2_d;
    logic [2:0] r_die_a, r_die_b;
    logic [3:0] r_dice1, r_dice2, r_point;
    logic       r_point_active, r_win, r_lose;
    logic [7:0] r_roll_count;
    logic       w_roll_pulse;
    logic [3:0] w_sum;
    logic [7:0] w_next_count;

    // Two-flop synchroniser plus edge detector: one pulse per press, none while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_roll_btn;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign w_roll_pulse = r_s2 & ~r_s2_d;

    // Die B advances only when die A wraps, so together they cycle through all 36 pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_die_a <= 3'd1;
            r_die_b <= 3'd1;
        end else if (r_die_a == 3'd6) begin
            r_die_a <= 3'd1;
            r_die_b <= (r_die_b == 3'd6) ? 3'd1 : r_die_b + 3'd1;
        end else begin
            r_die_a <= r_die_a + 3'd1;
        end
    end

    assign w_sum        = r_dice1 + r_dice2;
    assign w_next_count = (r_roll_count == SAT_ROLLS) ? r_roll_count : r_roll_count + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_dice1        <= 4'd0;
            r_dice2        <= 4'd0;
            r_point        <= 4'd0;
            r_point_active <= 1'b0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
            r_roll_count   <= 8'd0;
        end else begin
            case (r_state)
                IDLE, POINT: begin
                    if (w_roll_pulse) begin
                        r_dice1      <= {1'b0, r_die_a};
                        r_dice2      <= {1'b0, r_die_b};
                        r_roll_count <= w_next_count;
                        r_state      <= (r_state == IDLE) ? EVAL1 : EVAL2;
                    end
                end
                EVAL1: begin
                    if (w_sum == 4'd7 || w_sum == 4'd11) begin
                        r_win   <= 1'b1;
                        r_state <= WIN;
                    end else if (w_sum == 4'd2 || w_sum == 4'd3 || w_sum == 4'd12) begin
                        r_lose  <= 1'b1;
                        r_state <= LOSE;
                    end else begin
                        r_point        <= w_sum;
                        r_point_active <= 1'b1;
                        r_state        <= POINT;
                    end
                end
                EVAL2: begin
                    // Making the point takes priority; a seven only loses otherwise.
                    if (w_sum == r_point) begin
                        r_win          <= 1'b1;
                        r_point_active <= 1'b0;
                        r_state        <= WIN;
                    end else if (w_sum == 4'd7) begin
                        r_lose         <= 1'b1;
                        r_point_active <= 1'b0;
                        r_state        <= LOSE;
                    end else begin
                        r_state <= POINT;
                    end
                end
                WIN, LOSE: begin
                    if (w_roll_pulse) begin
                        r_dice1        <= 4'd0;
                        r_dice2        <= 4'd0;
                        r_point        <= 4'd0;
                        r_point_active <= 1'b0;
                        r_win          <= 1'b0;
                        r_lose         <= 1'b0;
                        r_roll_count   <= 8'd0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_dice1        = r_dice1;
    assign o_dice2        = r_dice2;
    assign o_point        = r_point;
    assign o_point_active = r_point_active;
    assign o_win          = r_win;
    assign o_lose         = r_lose;
    assign o_roll_count   = r_roll_count;

endmodule

// File: doc/craps_game_ctrl.md
# craps_game_ctrl

Game sequencer for the two-dice craps lab. It generates dice values from free-running counters and captures them on a roll-button press. It evaluates come-out and point rolls with a state machine and drives the `dice1`, `dice2`, `point` and `point_active` inputs of the seven-segment display block, plus `win`/`lose` LEDs and a roll counter. It sits between the board button/LED pins and the display driver.

## Interface
- `SAT_ROLLS`, default 8'd255: saturation value of `roll_count`.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `roll_btn` input 1: raw roll button, asynchronous to `clk`, active-high, assumed debounced externally.
- `dice1` output 4: latched die 1 value, 1..6; 0 before the first roll of a game.
- `dice2` output 4: latched die 2 value, 1..6; 0 before the first roll of a game.
- `point` output 4: established point, 4..10; 0 when none.
- `point_active` output 1: high while in the point phase.
- `win` output 1: high in state WIN.
- `lose` output 1: high in state LOSE.
- `roll_count` output 8: rolls in the current game, saturating at `SAT_ROLLS`.

## Operation
- Input sync: `roll_btn` → `s1` → `s2` flops; `s2_d` delays `s2`. `roll_pulse = s2 & ~s2_d`. This gives one pulse per press; holding the button produces no repeats.
- Dice counters, always running, unaffected by state:
  - `die_a` steps 1→2→…→6→1 every cycle.
  - `die_b` steps 1..6 only on cycles where `die_a` wraps 6→1.
- Roll capture: on `roll_pulse` in IDLE or POINT:
  - `dice1 <= die_a`, `dice2 <= die_b`.
  - `roll_count <= roll_count+1`, held at `SAT_ROLLS` once reached.
  - `sum = dice1+dice2` is computed 4-bit unsigned (2..12).
- States: IDLE, EVAL1, POINT, EVAL2, WIN, LOSE.
  - IDLE: `roll_pulse` → capture, go to EVAL1.
  - EVAL1:
    - sum 7 or 11 → WIN.
    - sum 2, 3 or 12 → LOSE.
    - otherwise `point <= sum`, `point_active <= 1`, go to POINT.
  - POINT: `roll_pulse` → capture, go to EVAL2.
  - EVAL2:
    - sum == `point` → WIN.
    - else sum == 7 → LOSE.
    - else → POINT.
  - WIN/LOSE: hold all outputs. `roll_pulse` → clear `dice1`, `dice2`, `point`, `point_active`, `roll_count` to 0, go to IDLE. The next press starts a new come-out roll.
- `point_active` drops to 0 on entry to WIN or LOSE; `point` keeps its value until cleared.
- `roll_pulse` while in EVAL1/EVAL2 is ignored. This is unreachable in practice because the pulse needs a release first.
- `win`/`lose` are registered and never high simultaneously.

## Timing
- Reset values:
  - state IDLE, `die_a` = 1, `die_b` = 1.
  - `s1`/`s2`/`s2_d` = 0.
  - `dice1`, `dice2`, `point` = 0.
  - `point_active`, `win`, `lose` = 0.
  - `roll_count` = 0.
- Sync latency:
  - `roll_btn` first sampled high at edge k → `roll_pulse` high between edges k+1 and k+2.
  - Dice are captured at edge k+2, using counter values present just before k+2.
  - EVAL result (WIN/LOSE/POINT, `point`, `point_active`) is visible after edge k+3.
- Counter values:
  - Let m = number of edges since reset release, with the capture edge counted as m.
  - Captured `die_a` = ((m−1) mod 6)+1.
  - Captured `die_b` = (((m−1) div 6) mod 6)+1.
- EVAL states last exactly one cycle.
- `rst` mid-game, including during EVAL: all registers go immediately to reset values, asynchronously. Normal operation resumes on the first edge after deassertion.

## Test plan
- Reset, no press for 100 cycles:
  - `dice1`, `dice2`, `point` = 0.
  - `point_active`, `win`, `lose`, `roll_count` = 0.
  - Internal `die_a` = 5 and `die_b` = 5 after 100 edges.
- Press timed so captured dice = (3,4):
  - Capture at edge k+2 with `dice1`=3, `dice2`=4, `roll_count`=1.
  - `win`=1 after k+3; `point_active` stays 0.
- Come-out (1,1):
  - `lose`=1.
  - Release, then press again → IDLE with all game outputs 0.
- Come-out (2,4): `point`=6, `point_active`=1.
  - Next roll (1,2): stay in POINT.
  - Next roll (5,1): `win`=1, `point_active`=0, `roll_count`=3.
- Point 8 established, then roll (3,4): `lose`=1, `point` remains 8.
- Hold `roll_btn` high 50 cycles: exactly one capture.
- Assert `rst` one cycle after EVAL1 entry: all outputs 0 with no clock edge needed.
